// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB slave-side bus between NUM_M masters.
// Holds a one-hot grant for one full transfer and supervises it with a grant watchdog and an access timeout.
module apb_rr_arbiter #(
  parameter int NUM_M       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int GNT_WAIT    = 4
) (
  input  logic                     i_pclk,
  input  logic                     i_prstn,
  input  logic [NUM_M-1:0]         i_req,
  input  logic                     i_bus_psel,
  input  logic                     i_bus_penable,
  input  logic                     i_bus_pready,
  output logic [NUM_M-1:0]         o_gnt,
  output logic [$clog2(NUM_M)-1:0] o_gnt_id,
  output logic                     o_gnt_valid,
  output logic                     o_busy,
  output logic                     o_timeout_err,
  output logic [$clog2(NUM_M)-1:0] o_err_id
);

  localparam int IDW = $clog2(NUM_M);
  localparam int WCW = $clog2(GNT_WAIT) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WCW-1:0] WLIM    = WCW'(GNT_WAIT - 1);
  localparam logic [TCW-1:0] TLIM    = TCW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_M - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_XFER    = 2'd2
  } state_t;

  state_t           r_state;
  logic [NUM_M-1:0] r_gnt;
  logic [IDW-1:0]   r_gnt_id;
  logic [IDW-1:0]   r_ptr;
  logic [WCW-1:0]   r_wcnt;
  logic [TCW-1:0]   r_tcnt;
  logic             r_timeout_err;
  logic [IDW-1:0]   r_err_id;

  logic [IDW:0]     w_pick_idle;
  logic [IDW:0]     w_pick_done;
  logic [IDW-1:0]   w_ptr_adv;
  logic             w_done;
  logic             w_stall;

  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    logic [IDW-1:0] nid;
    if (id == LAST_ID) nid = '0;
    else               nid = id + IDW'(1);
    return nid;
  endfunction

  // Returns {found, index} of the first set request scanning upward from ptr with wrap.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_M-1:0] req, input logic [IDW-1:0] ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      j = int'(ptr) + i;
      j = (j >= NUM_M) ? (j - NUM_M) : j;
      if (!found && req[IDW'(j)]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input logic [IDW-1:0] idx);
    return NUM_M'(1) << idx;
  endfunction

  assign w_ptr_adv   = next_id(r_gnt_id);
  assign w_pick_idle = rr_pick(i_req, r_ptr);
  // On completion the current master sits last in the scan, so it is regranted only if alone.
  assign w_pick_done = rr_pick(i_req, w_ptr_adv);
  assign w_done      = i_bus_psel & i_bus_penable & i_bus_pready;
  assign w_stall     = i_bus_penable & ~i_bus_pready;

  // Arbitration FSM with registered grant, pointer, watchdog counters and error flags.
  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_gnt_id      <= '0;
      r_ptr         <= '0;
      r_wcnt        <= '0;
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
      r_err_id      <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_idle[IDW]) begin
            r_gnt    <= onehot(w_pick_idle[IDW-1:0]);
            r_gnt_id <= w_pick_idle[IDW-1:0];
            r_wcnt   <= '0;
            r_state  <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (i_bus_psel) begin
            r_tcnt  <= '0;
            r_state <= S_XFER;
          end else if (!i_req[r_gnt_id] || (r_wcnt == WLIM)) begin
            r_gnt   <= '0;
            r_ptr   <= w_ptr_adv;
            r_state <= S_IDLE;
          end else begin
            r_wcnt <= r_wcnt + WCW'(1);
          end
        end
        S_XFER: begin
          if (w_done) begin
            r_ptr <= w_ptr_adv;
            if (w_pick_done[IDW]) begin
              r_gnt    <= onehot(w_pick_done[IDW-1:0]);
              r_gnt_id <= w_pick_done[IDW-1:0];
              r_wcnt   <= '0;
              r_state  <= S_GRANTED;
            end else begin
              r_gnt   <= '0;
              r_state <= S_IDLE;
            end
          end else if (!i_bus_psel) begin
            // Master abandoned the transfer: release quietly.
            r_gnt   <= '0;
            r_ptr   <= w_ptr_adv;
            r_state <= S_IDLE;
          end else if (w_stall) begin
            if (r_tcnt == TLIM) begin
              r_timeout_err <= 1'b1;
              r_err_id      <= r_gnt_id;
              r_gnt         <= '0;
              r_ptr         <= w_ptr_adv;
              r_state       <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + TCW'(1);
            end
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_gnt_id      = r_gnt_id;
  assign o_gnt_valid   = |r_gnt;
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_err_id      = r_err_id;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: expected output vectors are queued with the stimulus
// and compared against the DUT one cycle later.
module tb_apb_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       psel, pen, prdy;
  logic [3:0] gnt;
  logic [1:0] gnt_id, err_id;
  logic       gnt_valid, busy, terr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  apb_rr_arbiter #(.NUM_M(4), .TIMEOUT_CYC(16), .GNT_WAIT(4)) dut (
    .i_pclk        (clk),
    .i_prstn       (rst_n),
    .i_req         (req),
    .i_bus_psel    (psel),
    .i_bus_penable (pen),
    .i_bus_pready  (prdy),
    .o_gnt         (gnt),
    .o_gnt_id      (gnt_id),
    .o_gnt_valid   (gnt_valid),
    .o_busy        (busy),
    .o_timeout_err (terr),
    .o_err_id      (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [3:0] g, input logic [1:0] id,
                          input logic b, input logic te, input logic [1:0] eid);
    exp_q.push_back({g, id, |g, b, te, eid});
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    logic [10:0] e, o;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {gnt, gnt_id, gnt_valid, busy, terr, err_id};
    total_cnt++;
    assert (o === e) pass_cnt++;
    else $error("FAIL %s: observed gnt/id/vld/busy/terr/eid=%b_%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b_%b",
                t, o[10:7], o[6:5], o[4], o[3], o[2], o[1:0], e[10:7], e[6:5], e[4], e[3], e[2], e[1:0]);
  endtask

  task automatic cyc(input string tag, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic te, input logic [1:0] eid);
    push_exp(tag, g, id, b, te, eid);
    step();
    chk();
  endtask

  initial begin
    rst_n = 1'b0; req = 4'b0000; psel = 1'b0; pen = 1'b0; prdy = 1'b0;
    #3;
    push_exp("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    chk();
    step();
    step();
    rst_n = 1'b1;

    // Fairness: all requesting, zero-wait slaves, grants 0,1,2,3,0 back-to-back
    req = 4'b1111;
    cyc("rr_first", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      psel = 1'b1; pen = 1'b0; prdy = 1'b0;
      cyc($sformatf("rr_setup%0d", k), 4'(1 << (k % 4)), 2'(k % 4), 1'b1, 1'b0, 2'd0);
      pen = 1'b1; prdy = 1'b1;
      if (k < 4) begin
        cyc($sformatf("rr_next%0d", k), 4'(1 << ((k + 1) % 4)), 2'((k + 1) % 4), 1'b1, 1'b0, 2'd0);
      end else begin
        req = 4'b0000;
        cyc("rr_end", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
      end
    end
    psel = 1'b0; pen = 1'b0; prdy = 1'b0;

    // Single request from master 2, one transfer, release to IDLE (PTR becomes 3)
    req = 4'b0100;
    cyc("m2_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
    psel = 1'b1;
    cyc("m2_setup", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
    pen = 1'b1; prdy = 1'b1; req = 4'b0000;
    cyc("m2_done", 4'b0000, 2'd2, 1'b0, 1'b0, 2'd0);
    psel = 1'b0; pen = 1'b0; prdy = 1'b0;

    // Wrap-around from PTR=3: master 3 then master 0
    req = 4'b1001;
    cyc("wrap_m3", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    psel = 1'b1;
    cyc("wrap_m3_setup", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    pen = 1'b1; prdy = 1'b1;
    cyc("wrap_m0", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
    pen = 1'b0; prdy = 1'b0; req = 4'b0001;
    cyc("wrap_m0_setup", 4'b0001, 2'd0, 1'b1, 1'b0, 2'd0);
    pen = 1'b1; prdy = 1'b1; req = 4'b0000;
    cyc("wrap_done", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    psel = 1'b0; pen = 1'b0; prdy = 1'b0;

    // Grant watchdog: master 1 never asserts PSEL, grant withdrawn after 4 cycles
    req = 4'b0010;
    cyc("wd_grant", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cyc($sformatf("wd_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);
      else       cyc("wd_release", 4'b0000, 2'd1, 1'b0, 1'b0, 2'd0);
    end
    req = 4'b1011;
    cyc("wd_next_from2", 4'b1000, 2'd3, 1'b1, 1'b0, 2'd0);
    req = 4'b0000;
    cyc("req_drop_release", 4'b0000, 2'd3, 1'b0, 1'b0, 2'd0);

    // Access timeout on master 2
    req = 4'b0100;
    cyc("to_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
    psel = 1'b1;
    cyc("to_setup", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
    pen = 1'b1; prdy = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) cyc($sformatf("to_wait%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd0);
      else        cyc("to_abort", 4'b0000, 2'd2, 1'b0, 1'b1, 2'd2);
    end
    psel = 1'b0; pen = 1'b0; req = 4'b0000;
    cyc("to_pulse_end", 4'b0000, 2'd2, 1'b0, 1'b0, 2'd2);

    // PREADY rises on the threshold cycle: completion wins, no error
    req = 4'b0100;
    cyc("late_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    psel = 1'b1;
    cyc("late_setup", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    pen = 1'b1; prdy = 1'b0;
    for (int i = 1; i < 16; i++) begin
      cyc($sformatf("late_wait%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    end
    prdy = 1'b1; req = 4'b0000;
    cyc("late_done", 4'b0000, 2'd2, 1'b0, 1'b0, 2'd2);
    psel = 1'b0; pen = 1'b0; prdy = 1'b0;

    // Asynchronous reset in the middle of a stalled transfer
    req = 4'b0100;
    cyc("rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    psel = 1'b1;
    cyc("rst_setup", 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    pen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("rst_wait%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0, 2'd2);
    end
    #2 rst_n = 1'b0;
    #1;
    push_exp("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0);
    chk();
    psel = 1'b0; pen = 1'b0; req = 4'b0000;
    step();
    rst_n = 1'b1;
    // PTR was 3 before reset; from 0 the scan must pick master 1 over master 3
    req = 4'b1010;
    cyc("post_rst_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
